// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM states, frame
// framing constants and the {eight,pen,ohel} mode codes.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic MARK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  // Mode codes are {eight, pen, ohel}; the ohel bit is a don't-care when parity is off.
  localparam logic [2:0] MODE_7N0 = 3'b000;
  localparam logic [2:0] MODE_7N1 = 3'b001;
  localparam logic [2:0] MODE_7E  = 3'b010;
  localparam logic [2:0] MODE_7O  = 3'b011;
  localparam logic [2:0] MODE_8N0 = 3'b100;
  localparam logic [2:0] MODE_8N1 = 3'b101;
  localparam logic [2:0] MODE_8E  = 3'b110;
  localparam logic [2:0] MODE_8O  = 3'b111;

  function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [7:0] data,
                                                       input logic [1:0] post);
    return {MARK, post, data[6:0], START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_bit_decode.sv
// Combinational decoder for the two post-data bit slots {b8,b7} of a UART frame,
// selected by the {eight,pen,ohel} mode code.
module uart_tx_bit_decode
  import uart_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic       i_eight,
  input  logic       i_pen,
  input  logic       i_ohel,
  output logic [1:0] o_post
);

  logic w_par7;
  logic w_par8;

  assign w_par7 = ^i_data[6:0];
  assign w_par8 = ^i_data;

  // b7 carries either parity (7-bit) or data bit 7 (8-bit); unused slots are mark.
  always_comb begin
    o_post = {MARK, MARK};
    case ({i_eight, i_pen, i_ohel})
      MODE_7N0, MODE_7N1: o_post = {MARK, MARK};
      MODE_7E:            o_post = {MARK, w_par7};
      MODE_7O:            o_post = {MARK, ~w_par7};
      MODE_8N0, MODE_8N1: o_post = {MARK, i_data[7]};
      MODE_8E:            o_post = {w_par8, i_data[7]};
      MODE_8O:            o_post = {~w_par8, i_data[7]};
      default:            o_post = {MARK, MARK};
    endcase
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit controller: latches one byte plus frame config per write and
// shifts the 11-bit frame out LSB first. Optional line break via `TX_BREAK_EN.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_wr,
  input  logic [7:0]        tx_data,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
`ifdef TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              tx,
  output logic              tx_ready,
  output logic              tx_done
);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [7:0]              r_data;
  logic                    r_eight;
  logic                    r_pen;
  logic                    r_ohel;
  logic [BAUD_W-1:0]       r_baudK;
  logic [BAUD_W-1:0]       r_baudCnt;
  logic [3:0]              r_bitCnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_tx;
  logic                    r_ready;
  logic                    r_finish;
  logic                    r_done;
  logic [1:0]              w_post;
  logic                    w_break;
  logic                    w_accept;
  logic                    w_bitEnd;
  logic                    w_frameEnd;

`ifdef TX_BREAK_EN
  assign w_break = tx_break;
`else
  assign w_break = 1'b0;
`endif

  uart_tx_bit_decode u_decode (
    .i_data  (r_data),
    .i_eight (r_eight),
    .i_pen   (r_pen),
    .i_ohel  (r_ohel),
    .o_post  (w_post)
  );

  assign w_accept   = tx_wr && r_ready && !w_break && (r_state == IDLE);
  assign w_bitEnd   = (r_baudCnt == r_baudK - BAUD_W'(1));
  assign w_frameEnd = (r_state == SHIFT) && w_bitEnd && (r_bitCnt == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = LOAD;
      LOAD:    w_nextState = SHIFT;
      SHIFT:   if (w_frameEnd) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // tx lags r_shift[0] by one clock, so ready/done are delayed one extra clock
  // through r_finish to line up with the true end of the stop bit on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_eight   <= 1'b0;
      r_pen     <= 1'b0;
      r_ohel    <= 1'b0;
      r_baudK   <= BAUD_W'(1);
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '1;
      r_tx      <= MARK;
      r_ready   <= 1'b1;
      r_finish  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_finish <= w_frameEnd;
      r_done   <= r_finish;
      case (r_state)
        IDLE: begin
          r_tx <= w_break ? ~MARK : MARK;
          if (w_accept) begin
            r_data  <= tx_data;
            r_eight <= eight;
            r_pen   <= pen;
            r_ohel  <= ohel;
            r_baudK <= (baud_k == '0) ? BAUD_W'(1) : baud_k;
            r_ready <= 1'b0;
          end else begin
            r_ready <= ~w_break;
          end
        end
        LOAD: begin
          r_shift   <= buildFrame(r_data, w_post);
          r_bitCnt  <= '0;
          r_baudCnt <= '0;
          r_tx      <= MARK;
        end
        SHIFT: begin
          r_tx <= r_shift[0];
          if (w_bitEnd) begin
            r_shift   <= {MARK, r_shift[FRAME_BITS-1:1]};
            r_bitCnt  <= r_bitCnt + 4'd1;
            r_baudCnt <= '0;
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_W'(1);
          end
        end
        default: begin
          r_tx <= MARK;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: fixed frame vectors, random frames
// against a bit-list reference model, and mid-frame write / reset sequences.
module tb_uart_tx_engine;

  localparam int BAUD_W = 20;

  typedef struct {
    logic [7:0]        data;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic [BAUD_W-1:0] k;
    logic [10:0]       frame;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              txWr;
  logic [7:0]        txData;
  logic              eight;
  logic              pen;
  logic              ohel;
  logic [BAUD_W-1:0] baudK;
  logic              tx;
  logic              txReady;
  logic              txDone;
`ifdef TX_BREAK_EN
  logic              txBreak = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  uart_tx_engine #(.BAUD_W(BAUD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_wr    (txWr),
    .tx_data  (txData),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .baud_k   (baudK),
`ifdef TX_BREAK_EN
    .tx_break (txBreak),
`endif
    .tx       (tx),
    .tx_ready (txReady),
    .tx_done  (txDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference frame as a list of line bits: start, data bits LSB first,
  // optional parity making the total ones count even/odd, then mark fill.
  function automatic logic [10:0] refFrame(input logic [7:0] d, input logic e, input logic p, input logic o);
    logic [10:0] f;
    int dataBits;
    int ones;
    int pos;
    f = '1;
    f[0] = 1'b0;
    dataBits = e ? 8 : 7;
    ones = 0;
    pos = 1;
    for (int i = 0; i < dataBits; i++) begin
      f[pos] = d[i];
      if (d[i]) ones++;
      pos++;
    end
    if (p) f[pos] = o ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return f;
  endfunction

  // Sends one frame and checks it clock by clock. disturbAt >= 0 drives a
  // foreign write plus changed config/baud during that frame clock.
  task automatic applyStimulus(input logic [7:0] d, input logic e, input logic p, input logic o,
                               input logic [BAUD_W-1:0] k, input logic [10:0] expFrame,
                               input string tag, input int disturbAt);
    int keff;
    int unstable;
    int busy;
    int ghost;
    logic [10:0] got;
    keff = (k == 0) ? 1 : int'(k);
    unstable = 0;
    busy = 0;
    got = '1;
    txData = d;
    eight = e;
    pen = p;
    ohel = o;
    baudK = k;
    txWr = 1'b1;
    @(posedge clk); #1;
    txWr = 1'b0;
    txData = 8'($urandom);
    eight = 1'($urandom);
    pen = 1'($urandom);
    ohel = 1'($urandom);
    baudK = BAUD_W'($urandom_range(1, 9));
    checkOutput({tag, ".acceptReady"}, {31'd0, txReady}, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, ".loadLine"}, {29'd0, tx, txReady, txDone}, 32'b100);
    for (int c = 0; c < 11 * keff; c++) begin
      @(posedge clk); #1;
      if (c % keff == 0) got[c / keff] = tx;
      else if (tx !== got[c / keff]) unstable++;
      if (txReady !== 1'b0 || txDone !== 1'b0) busy++;
      txWr = (c == disturbAt);
      if (c == disturbAt) begin
        txData = 8'h55;
        baudK = BAUD_W'(8);
        eight = ~eight;
      end
    end
    checkOutput({tag, ".frame"}, {21'd0, got}, {21'd0, expFrame});
    checkOutput({tag, ".bitStable"}, unstable, 0);
    checkOutput({tag, ".busyFlags"}, busy, 0);
    @(posedge clk); #1;
    txWr = 1'b0;
    checkOutput({tag, ".endFlags"}, {29'd0, tx, txReady, txDone}, 32'b111);
    @(posedge clk); #1;
    checkOutput({tag, ".donePulse"}, {29'd0, tx, txReady, txDone}, 32'b110);
    if (disturbAt >= 0) begin
      ghost = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (tx !== 1'b1 || txReady !== 1'b1 || txDone !== 1'b0) ghost++;
      end
      checkOutput({tag, ".noGhostFrame"}, ghost, 0);
    end
  endtask

  initial begin
    int idleBad;
    int doneSeen;
    logic [7:0] rd;
    logic re, rp, ro;
    logic [BAUD_W-1:0] rk;

    vecs[0] = '{8'h41, 1'b0, 1'b0, 1'b0, BAUD_W'(4), 11'b11110000010};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, BAUD_W'(4), 11'b11101001010};
    vecs[2] = '{8'hA7, 1'b1, 1'b1, 1'b1, BAUD_W'(4), 11'b10101001110};
    vecs[3] = '{8'h03, 1'b0, 1'b1, 1'b0, BAUD_W'(4), 11'b11000000110};
    vecs[4] = '{8'h07, 1'b0, 1'b1, 1'b0, BAUD_W'(4), 11'b11100001110};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, BAUD_W'(2), 11'b10111111110};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b1, BAUD_W'(3), 11'b11100000000};
    vecs[7] = '{8'h81, 1'b1, 1'b0, 1'b0, BAUD_W'(1), 11'b11100000010};
    vecs[8] = '{8'h41, 1'b0, 1'b0, 1'b1, BAUD_W'(0), 11'b11110000010};

    reset = 1'b1;
    txWr = 1'b0;
    txData = 8'h00;
    eight = 1'b0;
    pen = 1'b0;
    ohel = 1'b0;
    baudK = BAUD_W'(4);
    #1;
    checkOutput("reset.state", {29'd0, tx, txReady, txDone}, 32'b110);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    idleBad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || txReady !== 1'b1 || txDone !== 1'b0) idleBad++;
    end
    checkOutput("idle50", idleBad, 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].data, vecs[i].eight, vecs[i].pen, vecs[i].ohel,
                    vecs[i].k, vecs[i].frame, $sformatf("vec%0d", i), -1);
    end

    applyStimulus(8'h41, 1'b0, 1'b0, 1'b0, BAUD_W'(4), 11'b11110000010, "midWrite", 10);
    applyStimulus(8'h41, 1'b0, 1'b0, 1'b0, BAUD_W'(4), 11'b11110000010, "finalBitWrite", 42);
    applyStimulus(8'h41, 1'b0, 1'b0, 1'b0, BAUD_W'(4), 11'b11110000010, "readyRiseWrite", 43);

    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom);
      re = 1'($urandom);
      rp = 1'($urandom);
      ro = 1'($urandom);
      rk = BAUD_W'($urandom_range(0, 5));
      applyStimulus(rd, re, rp, ro, rk, refFrame(rd, re, rp, ro), $sformatf("rand%0d", i), -1);
    end

    txData = 8'h41;
    eight = 1'b0;
    pen = 1'b0;
    ohel = 1'b0;
    baudK = BAUD_W'(4);
    txWr = 1'b1;
    @(posedge clk); #1;
    txWr = 1'b0;
    repeat (2 + 5 * 4 + 1) @(posedge clk);
    #1;
    checkOutput("midFrame.bit5", {31'd0, tx}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset.async", {29'd0, tx, txReady, txDone}, 32'b110);
    @(posedge clk); #1;
    reset = 1'b0;
    doneSeen = 0;
    idleBad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (txDone !== 1'b0) doneSeen++;
      if (tx !== 1'b1 || txReady !== 1'b1) idleBad++;
    end
    checkOutput("reset.noDone", doneSeen, 0);
    checkOutput("reset.idleAfter", idleBad, 0);
    applyStimulus(8'h41, 1'b0, 1'b0, 1'b0, BAUD_W'(4), 11'b11110000010, "postReset", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
